// File: rtl/core_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// and the mux/ALU select codes driven onto the datapath.
package core_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM; FUNCT defers to the instruction fields.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields to an ALU control code.
// illegal flags a funct3 the funct decode does not support, whatever alu_op is.
module alu_decoder
    import core_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       illegal
);
    logic [2:0] funct_ctrl;

    always_comb begin
        funct_ctrl = ALU_ADD;
        illegal    = 1'b0;
        case (funct3)
            3'b000:  funct_ctrl = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctrl = ALU_SLT;
            3'b110:  funct_ctrl = ALU_OR;
            3'b111:  funct_ctrl = ALU_AND;
            default: illegal    = 1'b1;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default:   alu_control = funct_ctrl;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R/I ALU ops, beq/bne, jal).
// Define CTRL_MEM_READY_EN to stall memory states on mem_ready with a wait-state timeout.
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic [2:0]         alu_control,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);
    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       funct_illegal;
    logic       mem_ok;
    logic       pc_en, ir_en, mw_en, rw_en, trap_flag;

`ifdef CTRL_MEM_READY_EN
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              mem_state, stall, timeout;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign mem_ok    = mem_ready;
    assign stall     = mem_state && !mem_ready;
    assign timeout   = stall && (wait_q == WCNT_W'(WAIT_MAX - 1));
    assign wait_d    = stall ? wait_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (reset) wait_q <= '0;
        else       wait_q <= wait_d;
    end
`else
    logic unused_mem_ready;
    localparam int unused_wait_max = WAIT_MAX;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    alu_decoder u_alu_dec (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .op_b5      (op[5]),
        .funct7b5   (funct7b5),
        .alu_control(alu_control),
        .illegal    (funct_illegal)
    );

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        mw_en      = 1'b0;
        rw_en      = 1'b0;
        trap_flag  = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_B;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_en      = mem_ok;
                pc_en      = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while the op is decoded.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = funct_illegal ? S_TRAP : S_EXECR;
                    OP_I:              state_d = funct_illegal ? S_TRAP : S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                rw_en      = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mw_en   = mem_ok;
                if (mem_ok) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_A;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                rw_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_A;
                alu_op    = ALUOP_SUB;
                state_d   = S_FETCH;
                case (funct3)
                    3'b000:  pc_en   = zero;
                    3'b001:  pc_en   = !zero;
                    default: state_d = S_TRAP;
                endcase
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_en     = 1'b1;
                state_d   = S_ALUWB;
            end
            S_TRAP:  trap_flag = 1'b1;
            default: state_d = S_FETCH;
        endcase
`ifdef CTRL_MEM_READY_EN
        if (timeout) state_d = S_TRAP;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Reset masks every side effect so an abandoned instruction commits nothing.
    assign pc_write  = pc_en && !reset;
    assign ir_write  = ir_en && !reset;
    assign mem_write = mw_en && !reset;
    assign reg_write = rw_en && !reset;
    assign illegal   = trap_flag && !reset;
    assign state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, corner sequences,
// and random instruction streams checked against a per-instruction trace model.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'h03;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    multicycle_ctrl #(.STATE_W(4), .WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        int          len;
        logic [19:0] tr;
        logic [2:0]  alu;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("reset_enables", {pc_write, ir_write, mem_write, reg_write, illegal}, 5'b0);
        next_cycle();
        check("reset_state", state_dbg, 4'd0);
        reset = 1'b0;
    endtask

    // Expected state sequence for one instruction, packed as {len, nibbles oldest-first}.
    function automatic logic [22:0] ref_trace(input logic [6:0] o, input logic [2:0] f3);
        bit f3_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
        case (o)
            7'h03:   return {3'd5, 20'h01234};
            7'h23:   return {3'd4, 20'h00125};
            7'h33:   return f3_ok ? {3'd4, 20'h00168} : {3'd3, 20'h0001F};
            7'h13:   return f3_ok ? {3'd4, 20'h00178} : {3'd3, 20'h0001F};
            7'h63:   return (f3 < 3'd2) ? {3'd3, 20'h00019} : {3'd4, 20'h0019F};
            7'h6F:   return {3'd4, 20'h001A8};
            default: return {3'd3, 20'h0001F};
        endcase
    endfunction

    function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o[5] && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Runs one instruction from FETCH; vector = {state, pc, ir, mem_wr, reg_wr, illegal, adr_src}.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int len, input logic [19:0] tr,
                             input logic [2:0] ealu, input string tag);
        logic [3:0] st;
        bit taken;
        logic [9:0] exp_v;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        taken = (o == 7'h63) && ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z));
        st = 4'd0;
        for (int k = 0; k < len; k++) begin
`ifdef CTRL_MEM_READY_EN
            mem_ready = 1'b1;
`else
            mem_ready = 1'($urandom);
`endif
            st = 4'(tr >> (4 * (len - 1 - k)));
            exp_v = {st, (k == 0) || (st == 4'd10) || (st == 4'd9 && taken), k == 0,
                     st == 4'd5, (st == 4'd4) || (st == 4'd8), st == 4'd15,
                     (st == 4'd3) || (st == 4'd5)};
            @(negedge clk);
            check(tag, {state_dbg, pc_write, ir_write, mem_write, reg_write, illegal, adr_src}, exp_v);
            if (st == 4'd6 || st == 4'd7) check({tag, "_alu"}, alu_control, ealu);
            next_cycle();
        end
        if (st == 4'd15) begin
            repeat (2) begin
                @(negedge clk);
                check({tag, "_trap_hold"}, {state_dbg, illegal, pc_write}, {4'd15, 1'b1, 1'b0});
                next_cycle();
            end
            do_reset();
        end
    endtask

    initial begin
        logic [22:0] t;
        logic [6:0]  ro;
        logic [2:0]  rf3;
        logic        rf7, rz;

        vecs[0]  = '{7'h03, 3'd2, 1'b0, 1'b0, 5, 20'h01234, 3'd0};
        vecs[1]  = '{7'h23, 3'd2, 1'b0, 1'b0, 4, 20'h00125, 3'd0};
        vecs[2]  = '{7'h33, 3'd0, 1'b1, 1'b0, 4, 20'h00168, 3'b001};
        vecs[3]  = '{7'h13, 3'd0, 1'b1, 1'b0, 4, 20'h00178, 3'b000};
        vecs[4]  = '{7'h33, 3'd6, 1'b0, 1'b0, 4, 20'h00168, 3'b011};
        vecs[5]  = '{7'h13, 3'd2, 1'b0, 1'b0, 4, 20'h00178, 3'b101};
        vecs[6]  = '{7'h33, 3'd7, 1'b0, 1'b0, 4, 20'h00168, 3'b010};
        vecs[7]  = '{7'h33, 3'd0, 1'b0, 1'b0, 4, 20'h00168, 3'b000};
        vecs[8]  = '{7'h63, 3'd0, 1'b0, 1'b1, 3, 20'h00019, 3'd0};
        vecs[9]  = '{7'h63, 3'd1, 1'b0, 1'b1, 3, 20'h00019, 3'd0};
        vecs[10] = '{7'h63, 3'd1, 1'b0, 1'b0, 3, 20'h00019, 3'd0};
        vecs[11] = '{7'h63, 3'd4, 1'b0, 1'b1, 4, 20'h0019F, 3'd0};
        vecs[12] = '{7'h6F, 3'd0, 1'b0, 1'b0, 4, 20'h001A8, 3'd0};
        vecs[13] = '{7'h33, 3'd1, 1'b0, 1'b0, 3, 20'h0001F, 3'd0};
        vecs[14] = '{7'h73, 3'd0, 1'b0, 1'b0, 3, 20'h0001F, 3'd0};
        vecs[15] = '{7'h13, 3'd5, 1'b0, 1'b0, 3, 20'h0001F, 3'd0};

        for (int i = 0; i < 16; i++) begin
            do_reset();
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].len,
                      vecs[i].tr, vecs[i].alu, $sformatf("vec%0d", i));
        end

        // Reset landing in MEMWRITE must suppress the store and return to FETCH.
        do_reset();
        op = 7'h23; funct3 = 3'd2; mem_ready = 1'b1;
        repeat (3) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_memwrite", {state_dbg, mem_write}, {4'd5, 1'b0});
        next_cycle();
        reset = 1'b0;
        check("rst_in_memwrite_next", state_dbg, 4'd0);
        run_instr(7'h03, 3'd2, 1'b0, 1'b0, 5, 20'h01234, 3'd0, "lw_after_abort");

        // Random back-to-back instruction stream.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: ro = 7'h03;
                1: ro = 7'h23;
                2: ro = 7'h33;
                3: ro = 7'h13;
                4: ro = 7'h63;
                5: ro = 7'h6F;
                default: ro = 7'($urandom);
            endcase
            rf3 = 3'($urandom);
            rf7 = 1'($urandom);
            rz  = 1'($urandom);
            t = ref_trace(ro, rf3);
            run_instr(ro, rf3, rf7, rz, int'(t[22:20]), t[19:0], ref_alu(ro, rf3, rf7),
                      $sformatf("rnd%0d_op%02h_f%0d", n, ro, rf3));
        end

`ifdef CTRL_MEM_READY_EN
        // MEMREAD stalled 3 cycles, then ready: state 3 for 4 cycles.
        do_reset();
        op = 7'h03; funct3 = 3'd2; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_lw_pre", state_dbg, 4'(k));
            next_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            @(negedge clk);
            check("stall_memread", {state_dbg, reg_write}, {4'd3, 1'b0});
            next_cycle();
        end
        @(negedge clk);
        check("stall_memwb", {state_dbg, reg_write}, {4'd4, 1'b1});
        next_cycle();
        // mem_ready never arrives during FETCH: 15 stall cycles then TRAP.
        mem_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("timeout_fetch", {state_dbg, ir_write, pc_write}, {4'd0, 1'b0, 1'b0});
            next_cycle();
        end
        @(negedge clk);
        check("timeout_trap", {state_dbg, illegal}, {4'd15, 1'b1});
        mem_ready = 1'b1;
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared datapath registers (PC, IR, OldPC, Data, A/B, ALUOut); all of them are synchronous-reset flops.
- Decodes the latched instruction fields each cycle and drives enables and mux selects.
- Supports: lw, sw, R-type and I-type ALU ops, beq/bne, jal.

Parameters:
- STATE_W, 4: width of the debug state output; must be ≥ 4.
- WAIT_MAX, 15: memory wait-state timeout in cycles; used only with CTRL_MEM_READY_EN.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- op  in  7  instr[6:0] from the IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory done; ignored unless CTRL_MEM_READY_EN
- pc_write  out  1  PC flop enable
- adr_src  out  1  memory address select: 0=PC, 1=result
- mem_write  out  1  data memory write enable
- ir_write  out  1  IR/OldPC flop enable
- reg_write  out  1  register file write enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=OldPC, 10=A
- alu_src_b  out  2  00=B, 01=imm, 10=const 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  high while in TRAP
- state_dbg  out  STATE_W  current state encoding

Behaviour:
- Moore FSM; next state is registered on posedge clk. All outputs are combinational from state and instruction fields, except pc_write (see BEQ).
- Reset (synchronous) → state FETCH=0. While reset is high, all enables (pc_write, ir_write, mem_write, reg_write) are forced 0 and illegal=0. Reset mid-instruction abandons it with no partial write.
- States and transitions (encodings fixed, for state_dbg):
  - FETCH(0): adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu add, result_src=10, pc_write=1 → DECODE.
  - DECODE(1): alu_src_a=01, alu_src_b=01, imm_src=10, add (branch target precompute). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - else → TRAP
  - MEMADR(2): alu_src_a=10, alu_src_b=01, imm_src = 00 for lw / 01 for sw, add → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD(3): adr_src=1, result_src=00 → MEMWB.
  - MEMWB(4): result_src=01, reg_write=1 → FETCH.
  - MEMWRITE(5): adr_src=1, result_src=00, mem_write=1 → FETCH.
  - EXECR(6): alu_src_a=10, alu_src_b=00, funct decode → ALUWB.
  - EXECI(7): alu_src_a=10, alu_src_b=01, imm_src=00, funct decode → ALUWB.
  - ALUWB(8): result_src=00, reg_write=1 → FETCH.
  - BRANCH(9): alu_src_a=10, alu_src_b=00, sub, result_src=00.
    - pc_write = zero for funct3=000, !zero for funct3=001.
    - Other funct3 → TRAP instead, with pc_write=0.
    - → FETCH.
  - JAL(10): alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 → ALUWB.
  - TRAP(15): all enables 0, illegal=1; held until reset.
- Funct decode:
  - funct3 000: sub iff op[5] & funct7b5, else add.
  - 010 → slt; 110 → or; 111 → and.
  - Other funct3 in DECODE for R/I-type → TRAP.
- Latencies (cycles): lw 5, sw 4, R/I 4, branch 3, jal 4.
- Any unused state encoding → FETCH on the next clock.

Optional Feature:
- Macro: CTRL_MEM_READY_EN.
- Defined: FETCH, MEMREAD and MEMWRITE hold, with outputs stable, until mem_ready=1. pc_write, ir_write and mem_write are asserted only in the ready cycle. A wait counter counts the stall cycles; reaching WAIT_MAX → TRAP.
- Undefined: mem_ready is ignored, every memory state lasts exactly 1 cycle, and no wait counter exists.

Decomposition:
- Package core_pkg holds:
  - state_t enum with the encodings above
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL)
  - alu_control, imm_src and result_src encodings
- Sub-module alu_decoder: combinational mapping (alu_op, funct3, op[5], funct7b5) → alu_control plus an illegal flag.

Test Plan:
- lw (op=0000011, funct3=010) from reset → state_dbg sequence 0,1,2,3,4,0; reg_write=1 only in cycle 5; ir_write=1 only in cycle 1.
- sw (0100011) → 0,1,2,5,0; mem_write=1 in cycle 4 with adr_src=1.
- R-type sub (0110011, funct3=000, funct7b5=1) → alu_control=001 in EXECR. I-type addi with funct7b5=1 → 000.
- beq with zero=1 → pc_write=1 in BRANCH. bne with zero=1 → pc_write=0. funct3=100 → state 15, illegal=1 until reset.
- reset asserted during MEMWRITE → mem_write=0 that cycle; next state 0.
- With CTRL_MEM_READY_EN: mem_ready low for 3 cycles in MEMREAD → state stays 3 for 4 cycles. mem_ready never high → TRAP after 15 cycles.
